// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1-to-8 registered demultiplexer.
package demux_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;
  localparam int CNT_W     = 16;

  typedef logic [SEL_W-1:0] lane_sel_t;

  // 3:8 one-hot decode of a lane index.
  function automatic logic [NUM_LANES-1:0] decode_sel(input lane_sel_t s);
    logic [NUM_LANES-1:0] onehot;
    onehot    = '0;
    onehot[s] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux8_reg_if.sv
// Producer/consumer bus bundle for demux8_reg.
// Handshake: a word moves on a rising clk edge exactly when its valid and
// ready are both 1 in the preceding cycle. A producer holding valid=1 keeps
// in_data/bcast stable until the transfer happens (sel may be retargeted);
// ready never depends on the valid of the same channel.
interface demux8_reg_if #(
  parameter int WIDTH = 64
);
  import demux_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  lane_sel_t                    sel;
  logic                         bcast;
  logic [NUM_LANES-1:0]         out_valid;
  logic [NUM_LANES-1:0]         out_ready;
  logic [NUM_LANES*WIDTH-1:0]   out_data;
  logic [CNT_W-1:0]             accept_cnt;

  // Producer and consumers side.
  modport master (
    output in_valid, in_data, sel, bcast, out_ready,
    input  in_ready, out_valid, out_data, accept_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_data, sel, bcast, out_ready,
    output in_ready, out_valid, out_data, accept_cnt
  );

endinterface

// File: rtl/demux_lane.sv
// One single-entry output lane: a data register plus valid flag.
// A load always wins over a drain, so a lane that is emptied and refilled
// in the same cycle keeps valid high with the new word.
module demux_lane #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Lane can take a new word when empty or when its consumer takes it now.
  always_comb begin
    o_free = ~r_valid | i_ready;
  end

  // Valid flag: set on load, cleared on a drain without refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Data register: only a load changes it, drained data stays visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux8_reg.sv
// 1-to-8 registered demultiplexer: steers each accepted producer word into
// the lane chosen by sel, or into all lanes when bcast is set, and counts
// accepted producer transfers.
module demux8_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  demux8_reg_if.slave bus
);

  logic [NUM_LANES-1:0]       w_free;
  logic [NUM_LANES-1:0]       w_lane_en;
  logic [NUM_LANES-1:0]       w_load;
  logic [NUM_LANES-1:0]       w_out_valid;
  logic [NUM_LANES*WIDTH-1:0] w_out_data;
  logic                       w_in_ready;
  logic                       w_accept;
  logic [CNT_W-1:0]           r_accept_cnt;

  // Ready looks only at the target lane(s), never at in_valid.
  always_comb begin
    w_in_ready = bus.bcast ? (&w_free) : w_free[bus.sel];
    w_accept   = bus.in_valid & w_in_ready;
  end

  // Lane enables: decoded sel gated by accept, widened to all lanes on bcast.
  always_comb begin
    w_lane_en = '0;
    if (w_accept) begin
      w_lane_en = decode_sel(bus.sel);
    end
    w_load = w_lane_en | {NUM_LANES{bus.bcast & w_accept}};
  end

  // Accepted producer transfers, one per accept (broadcast counts once).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_accept_cnt <= '0;
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[g]),
      .i_data  (bus.in_data),
      .i_ready (bus.out_ready[g]),
      .o_valid (w_out_valid[g]),
      .o_data  (w_out_data[g*WIDTH +: WIDTH]),
      .o_free  (w_free[g])
    );
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_data;
  assign bus.accept_cnt = r_accept_cnt;

endmodule
